side_vram_host_arbiter: RTL and testbench

- Sits between the core's side-VRAM monitor bundle (`side_ram_monitor`) and its override input (`side_ram_in`).
- Lets an external host (APF bridge / debug) read and write side VRAM on the CPU side, in gaps where CPU A is not selecting side VRAM.
- The core always has priority. A host access that collides with a core access is aborted and retried.
- When no host access is in flight, all fields pass through unchanged.

---
 rtl/athena.sv | 30 +++
 rtl/strobe_edge_tracker.sv | 45 ++++
 rtl/side_vram_host_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_side_vram_host_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/athena.sv
// Shared types for the Athena side-VRAM path: monitor/override bundle and
// host-arbiter state encoding.
package athena;

    localparam int unsigned SIDE_VRAM_AW = 11;
    localparam int unsigned SIDE_VA_W    = 13;

    typedef struct packed {
        logic [SIDE_VA_W-1:0] addr;
        logic [7:0]           data_in;
        logic [7:0]           data_out;
        logic                 nCS;
        logic                 VRD;
        logic                 nWE;
        logic                 VDG;
        logic                 VOE;
    } side_ram_t;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        CLAIM,
        WSTROBE,
        RSTROBE,
        ABORT,
        DONE,
        ERR
    } arb_state_e;

endpackage

// File: rtl/strobe_edge_tracker.sv
// Tracks the core's nWE and VDG strobes: edge pulses against the previous
// cycle plus a sticky "went low" flag, so a complete low-then-high strobe
// can be recognised after the host claims the bus.
module strobe_edge_tracker (
    input  logic i_clk,
    input  logic VIDEO_RSTn,
    input  logic clr,
    input  logic nWE,
    input  logic VDG,
    output logic we_rise,
    output logic we_seen_low,
    output logic vdg_rise,
    output logic vdg_seen_low
);

    logic nwe_q;
    logic vdg_q;
    logic we_fall;
    logic vdg_fall;

    // Edge detection against last cycle's strobe levels.
    always_comb begin
        we_fall  = nwe_q & ~nWE;
        we_rise  = ~nwe_q & nWE;
        vdg_fall = vdg_q & ~VDG;
        vdg_rise = ~vdg_q & VDG;
    end

    // Previous-level registers and sticky low flags; a falling edge landing
    // in the clear cycle still counts, since the override is already active.
    always_ff @(posedge i_clk) begin
        if (!VIDEO_RSTn) begin
            nwe_q        <= 1'b1;
            vdg_q        <= 1'b1;
            we_seen_low  <= 1'b0;
            vdg_seen_low <= 1'b0;
        end else begin
            nwe_q        <= nWE;
            vdg_q        <= VDG;
            we_seen_low  <= we_fall | (we_seen_low & ~clr);
            vdg_seen_low <= vdg_fall | (vdg_seen_low & ~clr);
        end
    end

endmodule

// File: rtl/side_vram_host_arbiter.sv
// Lets an external host borrow the CPU side of side VRAM in gaps between
// CPU A selects. The core always wins; colliding host accesses are aborted
// and retried. Strobes are never generated here, only borrowed from the core.
module side_vram_host_arbiter
    import athena::*;
#(
    parameter int unsigned HOST_AW    = SIDE_VRAM_AW,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned MAX_RETRY  = 7
) (
    input  logic               i_clk,
    input  logic               VIDEO_RSTn,
    input  side_ram_t          core_mon,
    output side_ram_t          core_in,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [HOST_AW-1:0] host_addr,
    input  logic [7:0]         host_wdata,
    output logic               host_ack,
    output logic [7:0]         host_rdata,
    output logic               host_err,
    output logic               host_busy
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    arb_state_e         state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RTY_W-1:0]   retry_cnt;
    logic               lat_we;
    logic [HOST_AW-1:0] lat_addr;
    logic [7:0]         lat_wdata;
    logic [7:0]         rd_cap;

    logic claim_active;
    logic collision;
    logic trk_clr;
    logic strobe_done;
    logic we_rise;
    logic we_seen_low;
    logic vdg_rise;
    logic vdg_seen_low;

    strobe_edge_tracker u_strobe (
        .i_clk        (i_clk),
        .VIDEO_RSTn   (VIDEO_RSTn),
        .clr          (trk_clr),
        .nWE          (core_mon.nWE),
        .VDG          (core_mon.VDG),
        .we_rise      (we_rise),
        .we_seen_low  (we_seen_low),
        .vdg_rise     (vdg_rise),
        .vdg_seen_low (vdg_seen_low)
    );

    // Claim window status; a CPU select inside the window is a collision.
    always_comb begin
        claim_active = (state == CLAIM) || (state == WSTROBE) || (state == RSTROBE);
        collision    = claim_active && !core_mon.nCS;
        trk_clr      = (state == CLAIM);
        strobe_done  = lat_we ? (we_rise && we_seen_low) : (vdg_rise && vdg_seen_low);
    end

    // Override mux: released in the same cycle the core selects, so the core
    // never sees host address/data while it owns the bus.
    always_comb begin
        core_in = core_mon;
        if (claim_active && core_mon.nCS) begin
            core_in.addr    = SIDE_VA_W'(lat_addr);
            core_in.data_in = lat_wdata;
            core_in.nCS     = 1'b0;
            core_in.VRD     = ~lat_we;
        end
    end

    // Arbiter FSM with registered handshake outputs and counters.
    always_ff @(posedge i_clk) begin
        if (!VIDEO_RSTn) begin
            state      <= IDLE;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_busy  <= 1'b0;
            host_rdata <= '0;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rd_cap     <= '0;
        end else begin
            host_ack <= 1'b0;
            host_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        host_busy <= 1'b1;
                    end
                end
                GAP: begin
                    if (!host_req) begin
                        state     <= IDLE;
                        gap_cnt   <= '0;
                        host_busy <= 1'b0;
                    end else if (!core_mon.nCS) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state     <= CLAIM;
                        gap_cnt   <= '0;
                        lat_we    <= host_we;
                        lat_addr  <= host_addr;
                        lat_wdata <= host_wdata;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                CLAIM: begin
                    if (collision) begin
                        state <= ABORT;
                    end else begin
                        state   <= lat_we ? WSTROBE : RSTROBE;
                        tmo_cnt <= '0;
                    end
                end
                WSTROBE, RSTROBE: begin
                    if (!lat_we && !core_mon.VDG) begin
                        rd_cap <= core_mon.data_out;
                    end
                    if (collision) begin
                        state <= ABORT;
                    end else if (strobe_done) begin
                        state     <= DONE;
                        host_ack  <= 1'b1;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        if (!lat_we) begin
                            host_rdata <= rd_cap;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        state     <= ERR;
                        host_err  <= 1'b1;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ABORT: begin
                    if (retry_cnt == RTY_W'(MAX_RETRY)) begin
                        state     <= ERR;
                        host_err  <= 1'b1;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        gap_cnt   <= '0;
                    end else begin
                        state     <= GAP;
                        retry_cnt <= retry_cnt + 1'b1;
                        gap_cnt   <= '0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
                ERR: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_side_vram_host_arbiter.sv
// Directed bench for side_vram_host_arbiter: reset, write, read, collision
// retry, retry exhaustion, timeout, gap qualification and request drop.
module tb_side_vram_host_arbiter;

    localparam int unsigned TIMEOUT = 1023;

    logic              i_clk;
    logic              VIDEO_RSTn;
    athena::side_ram_t core_mon;
    athena::side_ram_t core_in;
    logic              host_req;
    logic              host_we;
    logic [10:0]       host_addr;
    logic [7:0]        host_wdata;
    logic              host_ack;
    logic [7:0]        host_rdata;
    logic              host_err;
    logic              host_busy;

    int vectors;
    int miscompares;

    side_vram_host_arbiter #(
        .HOST_AW    (11),
        .GAP_CYCLES (2),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRY  (7)
    ) dut (
        .i_clk      (i_clk),
        .VIDEO_RSTn (VIDEO_RSTn),
        .core_mon   (core_mon),
        .core_in    (core_in),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .host_busy  (host_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #2;
    endtask

    task automatic core_defaults();
        core_mon.addr     = 13'h123;
        core_mon.data_in  = 8'h42;
        core_mon.data_out = 8'h00;
        core_mon.nCS      = 1'b1;
        core_mon.VRD      = 1'b1;
        core_mon.nWE      = 1'b1;
        core_mon.VDG      = 1'b1;
        core_mon.VOE      = 1'b1;
    endtask

    task automatic test_reset();
        VIDEO_RSTn = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        core_defaults();
        repeat (4) cyc();
        #1;
        vectors++;
        if (core_in.addr !== 13'h123) begin
            miscompares++;
            $display("FAIL reset_passthru_addr: got %h want %h", core_in.addr, 13'h123);
        end
        vectors++;
        if ({host_ack, host_err, host_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs: ack/err/busy got %b want 000", {host_ack, host_err, host_busy});
        end
        vectors++;
        if (host_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 00", host_rdata);
        end
        VIDEO_RSTn = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h1A5; host_wdata = 8'h5C;
        cyc(); #1;  // edge1: GAP
        vectors++;
        if (host_busy !== 1'b1 || core_in.addr !== 13'h123) begin
            miscompares++;
            $display("FAIL wr_gap_passthru: busy %b addr %h want 1 123", host_busy, core_in.addr);
        end
        cyc();      // edge2: GAP
        cyc(); #1;  // edge3: CLAIM
        vectors++;
        if (core_in.nCS !== 1'b0 || core_in.addr !== 13'h1A5) begin
            miscompares++;
            $display("FAIL wr_claim: nCS %b addr %h want 0 1a5", core_in.nCS, core_in.addr);
        end
        cyc();      // edge4: WSTROBE
        cyc(); core_mon.nWE = 1'b0; #1;
        vectors++;
        if ({core_in.addr, core_in.data_in, core_in.nCS, core_in.VRD, core_in.nWE} !== {13'h1A5, 8'h5C, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_override: addr %h din %h nCS %b VRD %b nWE %b want 1a5 5c 0 0 0",
                     core_in.addr, core_in.data_in, core_in.nCS, core_in.VRD, core_in.nWE);
        end
        cyc(); #1;
        vectors++;
        if (host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_early_ack: got %b want 0", host_ack);
        end
        cyc(); core_mon.nWE = 1'b1; #1;
        vectors++;
        if (host_ack !== 1'b0 || core_in.nCS !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rise_cycle: ack %b nCS %b want 0 0", host_ack, core_in.nCS);
        end
        cyc(); #1;
        vectors++;
        if (host_ack !== 1'b1 || host_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_ack: ack %b err %b want 1 0", host_ack, host_err);
        end
        host_req = 1'b0;
        cyc(); #1;
        vectors++;
        if ({host_ack, host_busy, core_in.nCS} !== 3'b001) begin
            miscompares++;
            $display("FAIL wr_idle: ack/busy/nCS got %b want 001", {host_ack, host_busy, core_in.nCS});
        end
    endtask

    task automatic test_read();
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h010; host_wdata = 8'hFF;
        repeat (4) cyc();  // edges 1..4: GAP, GAP, CLAIM, RSTROBE
        cyc(); core_mon.VDG = 1'b0; core_mon.data_out = 8'h3C; #1;
        vectors++;
        if ({core_in.addr, core_in.VRD, core_in.nCS, core_in.data_out} !== {13'h010, 1'b1, 1'b0, 8'h3C}) begin
            miscompares++;
            $display("FAIL rd_override: addr %h VRD %b nCS %b dout %h want 010 1 0 3c",
                     core_in.addr, core_in.VRD, core_in.nCS, core_in.data_out);
        end
        cyc(); core_mon.data_out = 8'hA7;
        cyc(); core_mon.VDG = 1'b1; core_mon.data_out = 8'h00; #1;
        vectors++;
        if (host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_early_ack: got %b want 0", host_ack);
        end
        cyc(); #1;
        vectors++;
        if (host_ack !== 1'b1 || host_rdata !== 8'hA7) begin
            miscompares++;
            $display("FAIL rd_ack_data: ack %b rdata %h want 1 a7", host_ack, host_rdata);
        end
        host_req = 1'b0;
        cyc(); #1;
        vectors++;
        if (host_ack !== 1'b0 || host_rdata !== 8'hA7 || host_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_hold: ack %b rdata %h busy %b want 0 a7 0", host_ack, host_rdata, host_busy);
        end
    endtask

    task automatic test_collision();
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h2B4; host_wdata = 8'h99;
        repeat (4) cyc();  // WSTROBE after edge4
        cyc(); core_mon.nCS = 1'b0; core_mon.addr = 13'h0777; #1;
        vectors++;
        if ({core_in.addr, core_in.data_in, core_in.nCS, core_in.VRD} !== {13'h0777, 8'h42, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL coll_release: addr %h din %h nCS %b VRD %b want 0777 42 0 1",
                     core_in.addr, core_in.data_in, core_in.nCS, core_in.VRD);
        end
        cyc(); core_mon.nCS = 1'b1; core_mon.addr = 13'h123; #1;  // ABORT
        vectors++;
        if (core_in.nCS !== 1'b1 || host_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_abort: nCS %b busy %b want 1 1", core_in.nCS, host_busy);
        end
        cyc(); #1;  // back in GAP
        vectors++;
        if (dut.retry_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL coll_retry_cnt: got %0d want 1", dut.retry_cnt);
        end
        cyc();      // GAP
        cyc(); #1;  // CLAIM again
        vectors++;
        if (core_in.addr !== 13'h2B4 || core_in.data_in !== 8'h99) begin
            miscompares++;
            $display("FAIL coll_reclaim: addr %h din %h want 2b4 99", core_in.addr, core_in.data_in);
        end
        cyc(); core_mon.nWE = 1'b0;
        cyc(); core_mon.nWE = 1'b1; #1;
        vectors++;
        if (host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_early_ack: got %b want 0", host_ack);
        end
        cyc(); #1;
        vectors++;
        if (host_ack !== 1'b1 || dut.retry_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL coll_done: ack %b retry %0d want 1 0", host_ack, dut.retry_cnt);
        end
        host_req = 1'b0;
        cyc();
    endtask

    task automatic test_retries();
        int  coll;
        bit  got_err;
        bit  got_ack;
        coll = 0; got_err = 1'b0; got_ack = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h055; host_wdata = 8'h01;
        for (int i = 0; i < 400 && !got_err; i++) begin
            cyc(); #1;
            if (host_ack) got_ack = 1'b1;
            if (host_err) begin
                got_err = 1'b1;
            end else if (core_mon.nCS && !core_in.nCS) begin
                core_mon.nCS = 1'b0;
                coll++;
            end else begin
                core_mon.nCS = 1'b1;
            end
        end
        vectors++;
        if (!got_err || coll != 8) begin
            miscompares++;
            $display("FAIL retry_exhaust: err_seen %b collisions %0d want 1 8", got_err, coll);
        end
        vectors++;
        if (got_ack) begin
            miscompares++;
            $display("FAIL retry_no_ack: ack_seen %b want 0", got_ack);
        end
        host_req = 1'b0; core_mon.nCS = 1'b1;
        cyc(); #1;
        vectors++;
        if (host_err !== 1'b0 || host_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL retry_idle: err %b busy %b want 0 0", host_err, host_busy);
        end
    endtask

    task automatic test_timeout();
        int err_at;
        bit last_ovr;
        err_at = 0; last_ovr = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h3FF; host_wdata = 8'hEE;
        repeat (3) cyc();
        #1;
        vectors++;
        if (core_in.nCS !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_claim: nCS %b want 0", core_in.nCS);
        end
        for (int i = 1; i <= 1100; i++) begin
            cyc(); #1;
            if (host_err) begin
                err_at = i;
                break;
            end
            last_ovr = ~core_in.nCS;
        end
        vectors++;
        if (err_at != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL tmo_cycle: err after %0d cycles want %0d", err_at, TIMEOUT + 1);
        end
        vectors++;
        if (last_ovr !== 1'b1 || core_in.nCS !== 1'b1 || host_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_release: prev_ovr %b nCS %b ack %b want 1 1 0", last_ovr, core_in.nCS, host_ack);
        end
        host_req = 1'b0;
        cyc(); #1;
        vectors++;
        if (host_err !== 1'b0 || host_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_idle: err %b busy %b want 0 0", host_err, host_busy);
        end
    endtask

    task automatic test_gap_hold();
        core_mon.nCS = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h0AA; host_wdata = 8'h3D;
        repeat (5) cyc();
        #1;
        vectors++;
        if (core_in.addr !== 13'h123 || host_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_hold: addr %h busy %b want 123 1", core_in.addr, host_busy);
        end
        core_mon.nCS = 1'b1;
        cyc(); #1;
        vectors++;
        if (core_in.nCS !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_early_claim: nCS %b want 1", core_in.nCS);
        end
        cyc(); #1;
        vectors++;
        if (core_in.nCS !== 1'b0 || core_in.addr !== 13'h0AA) begin
            miscompares++;
            $display("FAIL gap_claim: nCS %b addr %h want 0 0aa", core_in.nCS, core_in.addr);
        end
        cyc(); core_mon.nWE = 1'b0;
        cyc(); core_mon.nWE = 1'b1;
        cyc(); #1;
        vectors++;
        if (host_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_ack: got %b want 1", host_ack);
        end
        host_req = 1'b0;
        cyc();
    endtask

    task automatic test_req_drop();
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h001;
        cyc(); host_req = 1'b0; #1;
        vectors++;
        if (host_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_busy: got %b want 1", host_busy);
        end
        cyc(); #1;
        vectors++;
        if ({host_busy, host_ack, host_err, core_in.nCS} !== 4'b0001) begin
            miscompares++;
            $display("FAIL drop_idle: busy/ack/err/nCS got %b want 0001", {host_busy, host_ack, host_err, core_in.nCS});
        end
    endtask

    task automatic test_reset_mid();
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h077; host_wdata = 8'h11;
        repeat (4) cyc();
        cyc(); core_mon.nWE = 1'b0; VIDEO_RSTn = 1'b0;
        cyc(); #1;
        vectors++;
        if ({host_busy, host_ack, host_err, core_in.nCS} !== 4'b0001 || core_in.addr !== 13'h123) begin
            miscompares++;
            $display("FAIL rstmid_state: busy/ack/err/nCS %b addr %h want 0001 123",
                     {host_busy, host_ack, host_err, core_in.nCS}, core_in.addr);
        end
        VIDEO_RSTn = 1'b1; host_req = 1'b0; core_mon.nWE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            vectors++;
            if (host_ack !== 1'b0 || host_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_silent: ack %b err %b want 0 0", host_ack, host_err);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_write();
        test_read();
        test_collision();
        test_retries();
        test_gap_hold();
        test_req_drop();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
